// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, data width, command record and sequencer state shared by the ALU command front-end.
package alu_pkg;
   localparam int ALU_W = 4;
   localparam logic [3:0] OP_NOT_A  = 4'b0000;
   localparam logic [3:0] OP_NOT_B  = 4'b0001;
   localparam logic [3:0] OP_AND    = 4'b0010;
   localparam logic [3:0] OP_NAND   = 4'b0011;
   localparam logic [3:0] OP_OR     = 4'b0100;
   localparam logic [3:0] OP_NOR    = 4'b0101;
   localparam logic [3:0] OP_XOR    = 4'b0110;
   localparam logic [3:0] OP_XNOR   = 4'b0111;
   localparam logic [3:0] OP_DEC_A  = 4'b1000;
   localparam logic [3:0] OP_INC_B  = 4'b1001;
   localparam logic [3:0] OP_DEC_B  = 4'b1010;
   localparam logic [3:0] OP_ADD    = 4'b1011;
   localparam logic [3:0] OP_SUB_BA = 4'b1100;
   typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;
   typedef struct packed {
      logic [3:0]       sel;
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
   } cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry command FIFO with occupancy; full is judged before any same-cycle pop.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  cmd_t                   din,
   output cmd_t                   dout,
   output logic [$clog2(DEPTH):0] cnt,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   cmd_t           mem [DEPTH];
   logic [AW-1:0]  wp, rp;
   logic           do_push, do_pop;
   assign full    = cnt == (AW+1)'(DEPTH);
   assign empty   = cnt == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rp];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         wp  <= wp + AW'(do_push);
         rp  <= rp + AW'(do_pop);
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= din;
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, issues them one at a time and returns each settled result.
// Define ALU_FLAGS_EN to add registered zero/parity flags alongside out_res.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int SETTLE_CYC = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_sel,
   input  logic [ALU_W-1:0]       in_a,
   input  logic [ALU_W-1:0]       in_b,
   output logic [ALU_W-1:0]       alu_a,
   output logic [ALU_W-1:0]       alu_b,
   output logic [3:0]             alu_sel,
   input  logic [ALU_W-1:0]       alu_res,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ALU_W-1:0]       out_res,
`ifdef ALU_FLAGS_EN
   output logic                   out_zero,
   output logic                   out_parity,
`endif
   output logic [$clog2(DEPTH):0] fifo_cnt
);
   localparam int CW = $clog2(SETTLE_CYC + 1);
   state_t        state;
   logic [CW-1:0] cnt;
   cmd_t          in_cmd, head;
   logic          full, empty, pop;
   assign in_cmd   = '{sel: in_sel, a: in_a, b: in_b};
   assign in_ready = !full;
   assign pop      = state == IDLE && !empty;
   alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .pop   (pop),
      .din   (in_cmd),
      .dout  (head),
      .cnt   (fifo_cnt),
      .full  (full),
      .empty (empty)
   );
   // alu_* only load on a pop, so the ALU sees stable operands through SETTLE and HOLD
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         out_valid <= 1'b0;
         out_res   <= '0;
`ifdef ALU_FLAGS_EN
         out_zero   <= 1'b0;
         out_parity <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE:
               if (pop) begin
                  alu_a   <= head.a;
                  alu_b   <= head.b;
                  alu_sel <= head.sel;
                  cnt     <= '0;
                  state   <= SETTLE;
               end
            SETTLE: begin
               cnt <= cnt + CW'(1);
               if (cnt == CW'(SETTLE_CYC - 1)) begin
                  out_res   <= alu_res;
                  out_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
                  out_zero   <= alu_res == '0;
                  out_parity <= ^alu_res;
`endif
                  state     <= HOLD;
               end
            end
            HOLD:
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench with a behavioural ALU behind alu_* / alu_res.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;
   localparam int DEPTH = 4;
   localparam int SETTLE_CYC = 1;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0] in_sel = '0, in_a = '0, in_b = '0;
   logic [3:0] alu_a, alu_b, alu_sel, alu_res, out_res;
   logic in_ready, out_valid;
   logic [$clog2(DEPTH):0] fifo_cnt;
`ifdef ALU_FLAGS_EN
   logic out_zero, out_parity;
`endif
   int checks = 0, errors = 0;
   logic [3:0] exp_q[$];
   bit   rnd_rdy = 1'b0;
   logic rdy_fixed = 1'b0;
   logic stalled = 1'b0;
   logic [3:0] held = '0;

   alu_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_a(in_a), .in_b(in_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
`ifdef ALU_FLAGS_EN
      .out_zero(out_zero), .out_parity(out_parity),
`endif
      .fifo_cnt(fifo_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] alu(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
      case (s)
         OP_NOT_A:  return ~a;
         OP_NOT_B:  return ~b;
         OP_AND:    return a & b;
         OP_NAND:   return ~(a & b);
         OP_OR:     return a | b;
         OP_NOR:    return ~(a | b);
         OP_XOR:    return a ^ b;
         OP_XNOR:   return ~(a ^ b);
         OP_DEC_A:  return a - 4'd1;
         OP_INC_B:  return b + 4'd1;
         OP_DEC_B:  return b - 4'd1;
         OP_ADD:    return a + b;
         OP_SUB_BA: return b - a;
         default:   return 4'h0;
      endcase
   endfunction

   assign alu_res = alu(alu_sel, alu_a, alu_b);

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #2;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
   end

   // monitor: samples mid-cycle, so values seen here are those the next rising edge acts on
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         stalled = 1'b0;
      end else begin
         check("cnt_le_depth", int'(fifo_cnt <= DEPTH), 1);
         check("in_ready_vs_cnt", int'(in_ready), int'(fifo_cnt != DEPTH));
         if (in_valid && in_ready) exp_q.push_back(alu(in_sel, in_a, in_b));
         if (out_valid) begin
            if (stalled) check("stall_hold", int'(out_res), int'(held));
            stalled = !out_ready;
            held = out_res;
         end else stalled = 1'b0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_result", int'(out_res), -1);
            else begin
               logic [3:0] e;
               e = exp_q.pop_front();
               check("result", int'(out_res), int'(e));
`ifdef ALU_FLAGS_EN
               check("zero_flag", int'(out_zero), int'(e == 4'h0));
               check("parity_flag", int'(out_parity), int'(^e));
`endif
            end
         end
      end
   end

   task automatic push(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
      bit ok;
      in_sel = s;
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (ok) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      check("push_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int t = 0; t < 600 && exp_q.size() != 0; t++) @(posedge clk);
      check("drain", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int hs, vc;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_fifo_cnt", int'(fifo_cnt), 0);
      check("rst_alu_abs", int'({alu_a, alu_b, alu_sel}), 0);
      check("rst_out_res", int'(out_res), 0);
      rst = 1'b0;
      rdy_fixed = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      push(OP_AND, 4'b0101, 4'b0011);
      @(negedge clk);
      check("lat_edge0_valid", int'(out_valid), 0);
      @(negedge clk);
      check("lat_edge1_valid", int'(out_valid), 0);
      check("lat_issue_a", int'(alu_a), 5);
      @(negedge clk);
      check("lat_edge2_valid", int'(out_valid), 1);
      check("lat_res", int'(out_res), 1);
      @(posedge clk);
      #1;
      drain();
      push(OP_ADD, 4'b1001, 4'b1000);
      push(OP_SUB_BA, 4'b0101, 4'b0011);
      drain();
      rdy_fixed = 1'b0;
      for (int i = 0; i < 5; i++) push(4'($urandom_range(0, 12)), 4'($urandom), 4'($urandom));
      in_sel = OP_OR;
      in_a = 4'b1000;
      in_b = 4'b0001;
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("full_cnt", int'(fifo_cnt), DEPTH);
      check("full_in_ready", int'(in_ready), 0);
      check("full_out_valid", int'(out_valid), 1);
      @(posedge clk);
      #1;
      rdy_fixed = 1'b1;
      push(OP_OR, 4'b1000, 4'b0001);
      drain();
      for (int i = 0; i < 8; i++) push(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom));
      hs = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid && out_ready) hs++;
      end
      check("throughput_12cyc", hs, 4);
      @(posedge clk);
      #1;
      drain();
      rdy_fixed = 1'b0;
      push(OP_ADD, 4'd1, 4'd2);
      push(OP_ADD, 4'd3, 4'd4);
      push(OP_ADD, 4'd5, 4'd6);
      push(OP_ADD, 4'd7, 4'd8);
      rdy_fixed = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("pre_rst_cnt", int'(fifo_cnt), 2);
      check("pre_rst_valid", int'(out_valid), 0);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_cnt", int'(fifo_cnt), 0);
      check("mid_rst_alu", int'({alu_a, alu_b, alu_sel}), 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      vc = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) vc++;
      end
      check("no_stale_after_rst", vc, 0);
      @(posedge clk);
      #1;
      push(OP_XOR, 4'b1010, 4'b1010);
      push(OP_NOT_A, 4'b0000, 4'b0000);
      drain();
      rnd_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         push(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      rnd_rdy = 1'b0;
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
